event_capture_8x3: RTL and testbench



---
 rtl/event_capture_8x3_if.sv | 22 ++
 rtl/event_capture_8x3.sv | 88 ++++++++
 tb/tb_event_capture_8x3.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/event_capture_8x3_if.sv
// Valid/ready event channel between the capture block and the 8x3 encoder.
// The master drives the event and the slave answers with ready.
interface event_capture_8x3_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_onehot;
    logic [2:0] out_code;

    modport master (
        output out_valid,
        output out_onehot,
        output out_code,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_onehot,
        input  out_code,
        output out_ready
    );
endinterface

// File: rtl/event_capture_8x3.sv
// Synchronizes eight request lines, captures rising edges as pending events and
// issues them one per cycle, round-robin, as a one-hot vector plus binary code.
module event_capture_8x3 #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 i,
    input  logic                       clr_ovf,
    output logic [7:0]                 ovf,
    event_capture_8x3_if.master        out_if
);

    logic [7:0] r_sync [SYNC_STAGES];
    logic [7:0] r_prev;
    logic [7:0] r_pend;
    logic [7:0] r_ovf;
    logic [2:0] r_ptr;
    logic       r_valid;
    logic [7:0] r_onehot;
    logic [2:0] r_code;

    logic [7:0] w_s;
    logic [7:0] w_edge;
    logic [2:0] w_grant;
    logic       w_load;
    logic [7:0] w_grant_oh;
    logic [7:0] w_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(SYNC_STAGES); k++) r_sync[k] <= '0;
        end else begin
            r_sync[0] <= i;
            for (int k = 1; k < int'(SYNC_STAGES); k++) r_sync[k] <= r_sync[k-1];
        end
    end

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_edge = w_s & ~r_prev;

    // First pending line at or after the pointer, wrapping modulo 8.
    always_comb begin
        w_grant = r_ptr;
        for (int k = 7; k >= 0; k--) begin
            if (r_pend[r_ptr + 3'(k)]) w_grant = r_ptr + 3'(k);
        end
    end

    assign w_load     = (!r_valid || out_if.out_ready) && (r_pend != 8'h00);
    assign w_grant_oh = 8'h01 << w_grant;
    assign w_taken    = w_load ? w_grant_oh : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
            r_pend <= '0;
            r_ovf  <= '0;
            r_ptr  <= '0;
        end else begin
            r_prev <= w_s;
            // A fresh edge on a line being loaded re-arms it as a new event.
            r_pend <= (r_pend & ~w_taken) | w_edge;
            r_ovf  <= (clr_ovf ? 8'h00 : r_ovf) | (w_edge & r_pend & ~w_taken);
            if (w_load) r_ptr <= w_grant + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_onehot <= '0;
            r_code   <= '0;
        end else if (w_load) begin
            r_valid  <= 1'b1;
            r_onehot <= w_grant_oh;
            r_code   <= w_grant;
        end else if (r_valid && out_if.out_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign out_if.out_valid  = r_valid;
    assign out_if.out_onehot = r_onehot;
    assign out_if.out_code   = r_code;
    assign ovf               = r_ovf;

endmodule

// File: tb/tb_event_capture_8x3.sv
// Directed bench for event_capture_8x3: a behavioural model is compared every cycle,
// and literal expectations pin the latency and the issued event order.
module tb_event_capture_8x3;
    localparam int SYNC = 2;

    logic       clk;
    logic       rst_n;
    logic [7:0] i_drv;
    logic       clr_ovf;
    logic [7:0] ovf;

    event_capture_8x3_if bus ();

    event_capture_8x3 #(.SYNC_STAGES(SYNC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i       (i_drv),
        .clr_ovf (clr_ovf),
        .ovf     (ovf),
        .out_if  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;
    int xfer_q[$];
    int exp_seq[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_seq(input string name);
        check({name, "_count"}, xfer_q.size(), exp_seq.size());
        for (int k = 0; k < exp_seq.size(); k++) begin
            check({name, "_code"}, (k < xfer_q.size()) ? xfer_q[k] : -1, exp_seq[k]);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_hist [4];
    logic [7:0] m_prev, m_pend, m_ovf, m_oh;
    int         m_ptr, m_code, m_g;
    bit         m_valid, m_load;
    logic [7:0] m_s, m_edge, m_taken;

    function automatic int rr_pick(input logic [7:0] p, input int start);
        for (int k = 0; k < 8; k++) begin
            if (p[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    assign m_s     = m_hist[SYNC-1];
    assign m_edge  = m_s & ~m_prev;
    assign m_g     = rr_pick(m_pend, m_ptr);
    assign m_load  = (!m_valid || bus.out_ready) && (m_g >= 0);
    assign m_taken = m_load ? 8'(1 << m_g) : 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) m_hist[k] <= 8'h00;
            m_prev  <= 8'h00;
            m_pend  <= 8'h00;
            m_ovf   <= 8'h00;
            m_oh    <= 8'h00;
            m_ptr   <= 0;
            m_code  <= 0;
            m_valid <= 1'b0;
        end else begin
            m_hist[0] <= i_drv;
            for (int k = 1; k < 4; k++) m_hist[k] <= m_hist[k-1];
            m_prev <= m_s;
            m_pend <= (m_pend & ~m_taken) | m_edge;
            m_ovf  <= (clr_ovf ? 8'h00 : m_ovf) | (m_edge & m_pend & ~m_taken);
            if (m_load) begin
                m_valid <= 1'b1;
                m_code  <= m_g;
                m_oh    <= 8'(1 << m_g);
                m_ptr   <= (m_g + 1) % 8;
            end else if (m_valid && bus.out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            check("valid", int'(bus.out_valid), int'(m_valid));
            check("onehot", int'(bus.out_onehot), int'(m_oh));
            check("code", int'(bus.out_code), m_code);
            check("ovf", int'(ovf), int'(m_ovf));
            check("onehot0", int'($onehot0(bus.out_onehot)), 1);
        end
    end

    // A transfer happens at the next rising edge whenever valid and ready are both high here.
    always @(negedge clk) begin
        #1;
        if (rst_n && bus.out_valid && bus.out_ready) xfer_q.push_back(int'(bus.out_code));
    end

    task automatic step_post();
        @(posedge clk);
        #1;
    endtask

    task automatic negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        i_drv         = 8'h00;
        bus.out_ready = 1'b0;
        clr_ovf       = 1'b0;
        negs(2);
        rst_n = 1'b1;
        xfer_q.delete();
    endtask

    int n_valid;

    initial begin
        rst_n         = 1'b0;
        i_drv         = 8'h00;
        clr_ovf       = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("reset_valid", int'(bus.out_valid), 0);
        check("reset_onehot", int'(bus.out_onehot), 0);
        check("reset_ovf", int'(ovf), 0);
        cmp_en = 1'b1;
        do_reset();

        // Single pulse on line 3: four-edge latency, one cycle of valid.
        bus.out_ready = 1'b1;
        @(negedge clk);
        i_drv = 8'h08;
        step_post(); check("t1_e0_valid", int'(bus.out_valid), 0);
        step_post(); check("t1_e1_valid", int'(bus.out_valid), 0);
        step_post(); check("t1_e2_valid", int'(bus.out_valid), 0);
        @(negedge clk);
        i_drv = 8'h00;
        step_post();
        check("t1_e3_valid", int'(bus.out_valid), 1);
        check("t1_e3_onehot", int'(bus.out_onehot), 8'h08);
        check("t1_e3_code", int'(bus.out_code), 3);
        step_post(); check("t1_e4_valid", int'(bus.out_valid), 0);
        negs(4);
        exp_seq = '{3};
        check_seq("t1_seq");

        // All lines rise together: codes 0..7 back to back.
        do_reset();
        bus.out_ready = 1'b1;
        @(negedge clk);
        i_drv   = 8'hFF;
        n_valid = 0;
        repeat (14) begin
            step_post();
            n_valid += int'(bus.out_valid);
        end
        check("t2_valid_cycles", n_valid, 8);
        exp_seq = '{0, 1, 2, 3, 4, 5, 6, 7};
        check_seq("t2_seq");
        @(negedge clk);
        i_drv = 8'h00;
        negs(4);

        // Backpressure: code 5 held, then 5 and 2 drain.
        do_reset();
        @(negedge clk);
        i_drv = 8'h20;
        negs(2);
        i_drv = 8'h24;
        negs(6);
        check("t3_held_valid", int'(bus.out_valid), 1);
        check("t3_held_code", int'(bus.out_code), 5);
        bus.out_ready = 1'b1;
        negs(4);
        exp_seq = '{5, 2};
        check_seq("t3_seq");
        check("t3_idle", int'(bus.out_valid), 0);
        i_drv = 8'h00;
        negs(4);

        // Overrun on line 6 while its event is pending.
        do_reset();
        @(negedge clk);
        i_drv = 8'h01;
        negs(6);
        for (int p = 0; p < 3; p++) begin
            i_drv = 8'h41;
            negs(2);
            i_drv = 8'h01;
            negs(2);
        end
        negs(4);
        check("t4_ovf", int'(ovf), 8'h40);
        check("t4_held_code", int'(bus.out_code), 0);
        bus.out_ready = 1'b1;
        negs(5);
        exp_seq = '{0, 6};
        check_seq("t4_seq");
        check("t4_ovf_sticky", int'(ovf), 8'h40);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        step_post();
        check("t4_ovf_clr", int'(ovf), 0);
        @(negedge clk);
        i_drv = 8'h00;
        negs(4);

        // Round robin after grant 4: line 6 precedes line 1.
        do_reset();
        @(negedge clk);
        i_drv = 8'h10;
        negs(6);
        check("t5_first_code", int'(bus.out_code), 4);
        i_drv = 8'h52;
        negs(5);
        bus.out_ready = 1'b1;
        negs(5);
        exp_seq = '{4, 6, 1};
        check_seq("t5_seq");
        i_drv = 8'h00;
        negs(4);

        // Reset mid-operation, then a line held high across release.
        do_reset();
        @(negedge clk);
        i_drv = 8'h0E;
        negs(6);
        check("t6_pre_valid", int'(bus.out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", int'(bus.out_valid), 0);
        check("t6_rst_onehot", int'(bus.out_onehot), 0);
        check("t6_rst_code", int'(bus.out_code), 0);
        check("t6_rst_ovf", int'(ovf), 0);
        i_drv = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        xfer_q.delete();
        bus.out_ready = 1'b1;
        n_valid = 0;
        repeat (8) begin
            step_post();
            n_valid += int'(bus.out_valid);
        end
        check("t6_quiet_valid", n_valid, 0);
        @(negedge clk);
        rst_n = 1'b0;
        i_drv = 8'h01;
        negs(2);
        rst_n = 1'b1;
        xfer_q.delete();
        negs(10);
        exp_seq = '{0};
        check_seq("t6_held_seq");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
